// File: rtl/ir_queue.sv
// ir_queue: circular instruction queue between the memory data bus and decode.
// Buffers up to DEPTH words of WIDTH bits and presents the oldest word on d_out.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset (clears pointers, count, ovf, storage)
//   d_in   instruction word from the memory bus
//   wr_en  push d_in this cycle
//   rd_en  decoder consumes the head word this cycle
//   flush  discard all entries; wins over push and pop
//   d_out  head word, zero when empty
//   valid  d_out holds a real instruction
//   full   count == DEPTH
//   empty  count == 0
//   count  number of stored entries, 0..DEPTH
//   ovf    sticky overflow flag, cleared by reset or flush
//
// Optional feature: define IR_QUEUE_BYPASS_EN to forward d_in to d_out while
// the queue is empty; a word read in the same cycle is then never stored.
module ir_queue #(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             flush,
  output logic [WIDTH-1:0] d_out,
  output logic             valid,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             ovf
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             ovf_q;

  logic full_c;
  logic empty_c;
  logic bypass_c;
  logic push_c;
  logic pop_c;
  logic drop_c;

  // Status decoded from the occupancy register
  assign empty_c = (cnt == CW'(0));
  assign full_c  = (cnt == CW'(DEPTH));

`ifdef IR_QUEUE_BYPASS_EN
  // Word forwarded and consumed in the same cycle never touches storage
  assign bypass_c = empty_c && !flush && wr_en && rd_en;
`else
  assign bypass_c = 1'b0;
`endif

  // A read frees a slot this cycle, so a full queue still accepts a push with rd_en
  assign push_c = wr_en && (!full_c || rd_en) && !bypass_c;
  assign pop_c  = rd_en && !empty_c;
  assign drop_c = wr_en && full_c && !rd_en;

  // Pointers, occupancy and overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_c, pop_c})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (drop_c) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Storage; flush leaves contents intact since empty masks d_out anyway
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (push_c && !flush) begin
      mem[wr_ptr] <= d_in;
    end
  end

  // Head presentation
  always_comb begin
    d_out = '0;
    valid = 1'b0;
    if (!empty_c) begin
      d_out = mem[rd_ptr];
      valid = 1'b1;
    end
`ifdef IR_QUEUE_BYPASS_EN
    else if (!flush) begin
      d_out = d_in;
      valid = wr_en;
    end
`endif
  end

  assign full  = full_c;
  assign empty = empty_c;
  assign count = cnt;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_ir_queue.sv
// tb_ir_queue: directed and randomized checks of ir_queue against a queue-based model.
module tb_ir_queue;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] d_in;
  logic             wr_en;
  logic             rd_en;
  logic             flush;
  logic [WIDTH-1:0] d_out;
  logic             valid;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             ovf;

  ir_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .d_in  (d_in),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .flush (flush),
    .d_out (d_out),
    .valid (valid),
    .full  (full),
    .empty (empty),
    .count (count),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents as a FIFO queue plus the sticky error bit
  logic [WIDTH-1:0] mq[$];
  logic             m_ovf;

  int n_pass;
  int n_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model_update(input logic w, input logic r, input logic f,
                                       input logic [WIDTH-1:0] d);
    int sz;
    sz = mq.size();
    if (f) begin
      mq.delete();
      m_ovf = 1'b0;
      return;
    end
`ifdef IR_QUEUE_BYPASS_EN
    if (sz == 0 && w && r) return;
`endif
    if (r && sz > 0) void'(mq.pop_front());
    if (w) begin
      if (sz < int'(DEPTH) || r) mq.push_back(d);
      else m_ovf = 1'b1;
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, ".full"},  32'(full),  32'(mq.size() == int'(DEPTH)));
    chk({tag, ".valid"}, 32'(valid), 32'(mq.size() != 0));
    chk({tag, ".d_out"}, 32'(d_out), (mq.size() == 0) ? 32'h0 : 32'(mq[0]));
    chk({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
  endtask

  // One clock of stimulus; inputs are cleared after the edge so outputs reflect state only
  task automatic step(input string tag, input logic w, input logic r, input logic f,
                      input logic [WIDTH-1:0] d);
    @(negedge clk);
    wr_en = w; rd_en = r; flush = f; d_in = d;
    @(posedge clk);
    model_update(w, r, f, d);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; d_in = '0;
    #1;
    check_all(tag);
  endtask

  logic [WIDTH-1:0] pat [4];

  initial begin
    n_pass = 0; n_total = 0;
    mq.delete(); m_ovf = 1'b0;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; d_in = '0;
    pat[0] = 16'h1111; pat[1] = 16'h2222; pat[2] = 16'h3333; pat[3] = 16'h4444;

    // Reset state
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b1;

    // Fill and drain
    for (int i = 0; i < 4; i++) step("fill", 1'b1, 1'b0, 1'b0, pat[i]);
    chk("fill.full_const", 32'(full), 32'd1);
    chk("fill.count_const", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain.head_const", 32'(d_out), 32'(pat[i]));
      step("drain", 1'b0, 1'b1, 1'b0, '0);
    end
    chk("drain.empty_const", 32'(empty), 32'd1);
    step("pop_empty", 1'b0, 1'b1, 1'b0, '0);

    // Overflow, then push+pop while full
    for (int i = 0; i < 4; i++) step("refill", 1'b1, 1'b0, 1'b0, pat[i]);
    step("overflow", 1'b1, 1'b0, 1'b0, 16'h5555);
    chk("overflow.ovf_const", 32'(ovf), 32'd1);
    chk("overflow.head_const", 32'(d_out), 32'h1111);
    step("full_pushpop", 1'b1, 1'b1, 1'b0, 16'h6666);
    chk("full_pushpop.count_const", 32'(count), 32'd4);
    chk("full_pushpop.head_const", 32'(d_out), 32'h2222);
    for (int i = 0; i < 3; i++) step("drain2", 1'b0, 1'b1, 1'b0, '0);
    chk("drain2.last_const", 32'(d_out), 32'h6666);
    step("drain2", 1'b0, 1'b1, 1'b0, '0);

    // Asynchronous reset with three entries stored
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 1'b0, 1'b0, pat[i]);
    #1 rst = 1'b0;
    #1;
    chk("async_rst.count", 32'(count), 32'd0);
    chk("async_rst.empty", 32'(empty), 32'd1);
    chk("async_rst.d_out", 32'(d_out), 32'h0);
    chk("async_rst.valid", 32'(valid), 32'd0);
    mq.delete(); m_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_all("post_rst");

    // Wrap-around with push/pop pairs
    for (int i = 0; i < 10; i++) begin
      step("wrap_push", 1'b1, 1'b0, 1'b0, 16'(i));
      chk("wrap.head_const", 32'(d_out), 32'(i));
      chk("wrap.count_le1", 32'(count <= CW'(1)), 32'd1);
      step("wrap_pop", 1'b0, 1'b1, 1'b0, '0);
    end

    // Flush priority, also clearing a set overflow flag
    for (int i = 0; i < 5; i++) step("pre_flush", 1'b1, 1'b0, 1'b0, pat[i % 4]);
    step("pre_flush_pop", 1'b0, 1'b1, 1'b0, '0);
    step("pre_flush_pop", 1'b0, 1'b1, 1'b0, '0);
    step("flush", 1'b1, 1'b1, 1'b1, 16'hBEEF);
    chk("flush.count_const", 32'(count), 32'd0);
    chk("flush.ovf_const", 32'(ovf), 32'd0);
    chk("flush.valid_const", 32'(valid), 32'd0);

`ifdef IR_QUEUE_BYPASS_EN
    // Bypass while empty: visible combinationally and not stored
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b1; d_in = 16'hABCD;
    #1;
    chk("bypass.d_out", 32'(d_out), 32'hABCD);
    chk("bypass.valid", 32'(valid), 32'd1);
    @(posedge clk);
    model_update(1'b1, 1'b1, 1'b0, 16'hABCD);
    #1 wr_en = 1'b0; rd_en = 1'b0; d_in = '0;
    #1 check_all("bypass");
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic w, r, f;
      w = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 50);
      f = ($urandom_range(0, 99) < 4);
      step("rand", w, r, f, 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
